// File: rtl/memory.sv
`default_nettype none
// ============================================================================
// Module   : memory
// Purpose  : Single-port DEPTH x DATA_WIDTH data/program memory. This is the
//            responder side of the CPU memory interface. After reset, a clear
//            sequencer zeroes the array. A streaming loader port can place a
//            program or data burst into the array while the CPU port is
//            parked.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1             clock, rising edge
//   rst       in   1             synchronous active-high reset
//   addr      in   ADDR_WIDTH    CPU access address
//   data      in   DATA_WIDTH    CPU write data
//   we        in   1             CPU write enable
//   mem       out  DATA_WIDTH    registered read data (1-cycle latency)
//   rdy       out  1             CPU port serviced (IDLE)
//   ld_start  in   1             start load burst (honoured in IDLE only)
//   ld_base   in   ADDR_WIDTH    first load address
//   ld_len    in   ADDR_WIDTH+1  burst word count, 0..DEPTH
//   ld_valid  in   1             ld_data valid
//   ld_data   in   DATA_WIDTH    load word
//   ld_ready  out  1             loader can accept a word
//   ld_done   out  1             one-cycle pulse, burst complete
// ============================================================================
module memory #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] mem,
  output logic                  rdy,
  input  logic                  ld_start,
  input  logic [ADDR_WIDTH-1:0] ld_base,
  input  logic [ADDR_WIDTH:0]   ld_len,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  ld_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic [ADDR_WIDTH-1:0]   ptr;
  // One bit wider than an address so a full-depth burst is representable.
  logic [ADDR_WIDTH:0]     cnt;
  logic [DATA_WIDTH-1:0]   array [DEPTH];

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    ld_accept;

  // Next-state and write-port steering. The single array write port is
  // shared by the clear sequencer, the CPU and the loader, one per state.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = addr;
    wr_data   = data;
    rdy       = 1'b0;
    ld_ready  = 1'b0;
    ld_accept = 1'b0;
    case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_ptr;
        wr_data = '0;
        if (clr_ptr == {ADDR_WIDTH{1'b1}}) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        rdy   = 1'b1;
        wr_en = we;
        if (ld_start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          ld_ready  = 1'b1;
          ld_accept = ld_valid;
          wr_en     = ld_valid;
          wr_addr   = ptr;
          wr_data   = ld_data;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Control registers and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ptr     <= '0;
      cnt     <= '0;
      mem     <= '0;
      ld_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      // The pulse lands in the first IDLE cycle after an exhausted burst.
      ld_done <= (state == LOAD) && (cnt == '0);
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          mem     <= '0;
        end
        IDLE: begin
          // Write-first: a same-cycle write is what the CPU reads back.
          mem <= we ? data : array[addr];
          if (ld_start) begin
            ptr <= ld_base;
            cnt <= ld_len;
          end
        end
        LOAD: begin
          if (ld_accept) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage itself carries no reset; CLEAR is what zeroes it.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      array[wr_addr] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_memory
// Purpose  : Self-checking bench for memory. Stimulus pushes expected read
//            data into a queue and a monitor pops and compares on each read
//            response. The reference is a plain word array.
// Revision : 1.0  initial release
// ============================================================================
module tb_memory;

  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0;
  logic          we = 1'b0;
  logic [DW-1:0] mem;
  logic          rdy;
  logic          ld_start = 1'b0;
  logic [AW-1:0] ld_base = '0;
  logic [AW:0]   ld_len = '0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          ld_done;

  always #5 clk = ~clk;

  memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .we(we), .mem(mem),
    .rdy(rdy), .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ld_words [$];
  logic          rd_req = 1'b0;
  logic          pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read issued while rdy was high produces data one cycle later.
  always @(posedge clk) pend <= rd_req && rdy && !rst;

  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_data: got %0h expected <none queued>", mem);
      end else begin
        chk("read_data", {16'h0, mem}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // One CPU cycle in IDLE; called and returns at a falling edge.
  task automatic cpu_op(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input logic rd);
    chk("rdy_idle", {31'h0, rdy}, 32'h1);
    addr = a; we = w; data = d; rd_req = rd;
    if (w) model[a] = d;
    if (rd) exp_q.push_back(model[a]);
    @(negedge clk);
    we = 1'b0; rd_req = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1; rd_req = 1'b0; we = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("rdy_clear", {31'h0, rdy}, 32'h0);
      chk("ld_done_clear", {31'h0, ld_done}, 32'h0);
      if (i == 0 || i == DEPTH - 1) chk("mem_clear", {16'h0, mem}, 32'h0);
      @(negedge clk);
    end
    chk("rdy_after_clear", {31'h0, rdy}, 32'h1);
  endtask

  // Burst of len words from ld_words. abort_after >= 0 returns mid-burst
  // (still in LOAD) after that many words so the caller can reset.
  task automatic load(input logic [AW-1:0] base, input logic [AW:0] len, input bit gap1,
                      input bit inject, input int abort_after);
    logic [AW-1:0] p;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          cw;
    bit            gapped;
    int            n;
    ca = AW'($urandom); cd = DW'($urandom); cw = 1'($urandom);
    chk("rdy_before_load", {31'h0, rdy}, 32'h1);
    // CPU access in the start cycle is still serviced.
    ld_start = 1'b1; ld_base = base; ld_len = len;
    addr = ca; we = cw; data = cd; rd_req = 1'b1;
    if (cw) model[ca] = cd;
    exp_q.push_back(model[ca]);
    @(negedge clk);
    ld_start = 1'b0; we = 1'b0; rd_req = 1'b0;
    ld_base = AW'($urandom); ld_len = 7'($urandom);
    p = base; n = 0; gapped = 1'b0;
    while (n < int'(len)) begin
      if (abort_after >= 0 && n == abort_after) begin
        ld_valid = 1'b0; we = 1'b0; ld_start = 1'b0;
        return;
      end
      chk("ld_ready_busy", {31'h0, ld_ready}, 32'h1);
      chk("rdy_busy", {31'h0, rdy}, 32'h0);
      chk("ld_done_busy", {31'h0, ld_done}, 32'h0);
      if (gap1 && n == 1 && !gapped) begin
        ld_valid = 1'b0;
        gapped = 1'b1;
      end else begin
        ld_valid = ($urandom_range(0, 3) != 0);
      end
      ld_data = ld_words[n];
      if (inject) begin
        we = 1'b1; addr = 6'd20; data = 16'hFFFF;
        ld_start = 1'($urandom); ld_len = 7'd1; ld_base = AW'($urandom);
      end
      if (ld_valid) begin
        model[p] = ld_data;
        p = p + 1'b1;
        n++;
      end
      @(negedge clk);
    end
    ld_valid = 1'b0; we = 1'b0; ld_start = 1'b0;
    chk("ld_ready_end", {31'h0, ld_ready}, 32'h0);
    chk("ld_done_early", {31'h0, ld_done}, 32'h0);
    chk("rdy_end", {31'h0, rdy}, 32'h0);
    @(negedge clk);
    chk("ld_done_pulse", {31'h0, ld_done}, 32'h1);
    chk("rdy_with_done", {31'h0, rdy}, 32'h1);
    @(negedge clk);
    chk("ld_done_single", {31'h0, ld_done}, 32'h0);
  endtask

  task automatic fill_words(input int n);
    ld_words.delete();
    for (int i = 0; i < n; i++) ld_words.push_back(DW'($urandom));
  endtask

  initial begin
    @(negedge clk);
    do_reset(3);
    cpu_op(6'd0, 1'b0, '0, 1'b1);
    cpu_op(6'd31, 1'b0, '0, 1'b1);
    cpu_op(6'd63, 1'b0, '0, 1'b1);

    cpu_op(6'd8, 1'b1, 16'hA5C3, 1'b0);
    cpu_op(6'd8, 1'b0, '0, 1'b1);
    cpu_op(6'd5, 1'b1, 16'h1234, 1'b1);

    ld_words.delete();
    ld_words.push_back(16'h1111); ld_words.push_back(16'h2222); ld_words.push_back(16'h3333);
    load(6'd8, 7'd3, 1'b1, 1'b0, -1);
    for (int a = 7; a <= 11; a++) cpu_op(AW'(a), 1'b0, '0, 1'b1);

    fill_words(4);
    load(6'd62, 7'd4, 1'b0, 1'b0, -1);
    for (int a = 60; a < 66; a++) cpu_op(AW'(a), 1'b0, '0, 1'b1);
    fill_words(0);
    load(6'd17, 7'd0, 1'b0, 1'b0, -1);
    for (int a = 15; a < 20; a++) cpu_op(AW'(a), 1'b0, '0, 1'b1);

    fill_words(5);
    load(6'd30, 7'd5, 1'b0, 1'b1, -1);
    for (int a = 18; a < 36; a++) cpu_op(AW'(a), 1'b0, '0, 1'b1);

    fill_words(DEPTH);
    load(AW'($urandom), 7'd64, 1'b0, 1'b0, -1);
    for (int a = 0; a < DEPTH; a++) cpu_op(AW'(a), 1'b0, '0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        int len;
        len = $urandom_range(0, 8);
        fill_words(len);
        load(AW'($urandom), 7'(len), 1'b0, 1'($urandom), -1);
      end else begin
        cpu_op(AW'($urandom), 1'($urandom), DW'($urandom), 1'($urandom));
      end
    end

    fill_words(5);
    load(6'd40, 7'd5, 1'b0, 1'b0, 2);
    do_reset(1);
    for (int a = 0; a < DEPTH; a++) cpu_op(AW'(a), 1'b0, '0, 1'b1);

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory.md
Name: memory

Overview:
- Single-port 64x16 data/program memory. It is the responder side of the CPU memory interface: the CPU drives addr/data/we and samples mem.
- It adds a post-reset clear sequencer and a streaming loader port. The testbench or a boot block uses the loader to place a program (from address 8) and data into memory before the CPU runs.
- It also provides a ready flag the CPU sequencer waits on.

Parameters:
DATA_WIDTH, 16, word width
ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH words

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
addr  input  ADDR_WIDTH  CPU access address
data  input  DATA_WIDTH  CPU write data
we  input  1  CPU write enable
mem  output  DATA_WIDTH  registered read data to CPU
rdy  output  1  high when CPU port is serviced (state IDLE)
ld_start  input  1  request load burst (sampled in IDLE only)
ld_base  input  ADDR_WIDTH  first load address, captured with ld_start
ld_len  input  ADDR_WIDTH+1  word count 0..DEPTH, captured with ld_start
ld_valid  input  1  ld_data valid this cycle
ld_data  input  DATA_WIDTH  load word
ld_ready  output  1  high in LOAD; a word is accepted when ld_valid && ld_ready
ld_done  output  1  one-cycle pulse when a burst completes

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst, sampled at the rising edge.
- Reset effects:
  - state <= CLEAR, clr_ptr <= 0.
  - mem, rdy, ld_ready and ld_done all reset to 0.
  - Array contents are not touched by rst itself; CLEAR zeroes them.
- Reset mid-LOAD: abandons the burst. No ld_done pulse; a full CLEAR follows.
- States:
  - CLEAR: each cycle array[clr_ptr] <= 0, clr_ptr++. After writing DEPTH-1 → IDLE, so CLEAR lasts exactly DEPTH (64) cycles.
    - CPU port and ld_start are ignored. mem holds 0, rdy=0.
  - IDLE: rdy=1.
    - Read: mem <= array[addr] every cycle, i.e. 1-cycle latency. Data is visible the cycle after addr is presented.
    - Write: if we, array[addr] <= data.
    - Read-during-write to the same address is write-first: mem <= data.
    - If ld_start: capture ptr <= ld_base and cnt <= ld_len, then → LOAD. A CPU access in that same cycle is still serviced.
  - LOAD: rdy=0. CPU we is ignored (no write) and mem holds its last value. ld_ready=1 unless cnt==0.
    - On ld_valid: array[ptr] <= ld_data, ptr <= ptr+1 (mod DEPTH, so 63 wraps to 0), cnt--.
    - When cnt==0 at the start of a cycle → IDLE with ld_done=1 for that one cycle, ld_ready=0.
    - ld_len=0: LOAD lasts one cycle, writes nothing and pulses ld_done.
    - ld_valid gaps stall the burst with no timeout.
    - ld_start while in LOAD or CLEAR is ignored.
- Out-of-range: none is possible; addresses are naturally modulo DEPTH.
- Widths: cnt is ADDR_WIDTH+1 bits so ld_len=64 (full fill) is representable. A full-depth burst from any base wraps and rewrites all 64 words.
- The ld_done pulse and the first IDLE cycle coincide: rdy=1 in that same cycle.

Test Plan:
1. Reset then idle → rdy=0 for 64 cycles after rst falls, rdy=1 on cycle 65; reading addrs 0, 31, 63 returns 0x0000.
2. IDLE: write addr=8 data=0xA5C3; next cycle read addr=8 → mem=0xA5C3 one cycle later. Same-cycle we=1 addr=5 data=0x1234 with read addr=5 → mem=0x1234 next cycle (write-first).
3. Load ld_base=8, ld_len=3, data 0x1111/0x2222/0x3333 with one ld_valid gap → ld_done pulses once, rdy returns. Reads of 8/9/10 give those words; 7 and 11 stay 0.
4. Load ld_base=62, ld_len=4 → words land at 62, 63, 0, 1 (wrap); ld_len=0 → ld_done one cycle after entering LOAD, no array change.
5. During LOAD, CPU we=1 addr=20 data=0xFFFF → addr 20 still 0 afterward; ld_start asserted mid-burst → ignored, burst count unaffected.
6. rst asserted after 2 of 5 load words → no ld_done, CLEAR runs 64 cycles, all addresses read 0x0000 including the 2 loaded ones.
